barcode_raster_gen: RTL
=======================

# barcode_raster_gen

Generates the Code 128-C style configuration barcode (start, three data symbols, stop; 57 modules) from kernel, stride and dilation values. It streams the barcode as 8-bit grayscale pixels over a valid/ready interface, one module per pixel, repeated over BAR_HEIGHT rows. It is the transmit-side counterpart of the barcode decode stage: test-image builders and self-check paths use it to produce the image rows that stage consumes.

## Interface
- ROW_WIDTH, 64: pixels per emitted row; must be ≥ COL_OFFSET+57.
- COL_OFFSET, 0: column of the first barcode module.
- BAR_HEIGHT, 10: number of identical rows emitted per frame.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  frame request; sampled only in IDLE.
- i_kernel_size  in  8  legal values 1..3.
- i_stride_size  in  8  legal values 1..3.
- i_dilation_size  in  8  legal values 1..3.
- o_busy  out  1  high from LOAD through DONE.
- o_err  out  1  last request had an illegal value.
- o_done  out  1  one-cycle end-of-request pulse.
- o_pix_valid  out  1  pixel available.
- i_pix_ready  in  1  consumer accepts pixel.
- o_pix_data  out  8  8'h00 for module bit 1 (bar); 8'hFF for bit 0 or padding.
- o_pix_row  out  $clog2(BAR_HEIGHT)  row index of current pixel.
- o_pix_col  out  $clog2(ROW_WIDTH)  column index of current pixel.
- o_pix_last  out  1  high on the final pixel of the frame.

## Operation
- Symbol encoding: value 1 → 11001101100, 2 → 11001100110, 3 → 10010011000. Start is 11010011100; stop is 1100011101011.
- Frame word, MSB first: {start, sym(kernel), sym(stride), sym(dilation), stop}.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE→LOAD on i_start. Operands are captured in the same edge.
- LOAD, one cycle: range-check operands and build the 57-bit word.
  - Any operand outside 1..3: set o_err=1 and go to DONE; no pixels are emitted.
  - Otherwise: clear o_err, zero row/col, go to EMIT.
- EMIT output mapping: col in [COL_OFFSET, COL_OFFSET+56] outputs bit 56-(col-COL_OFFSET); all other cols output 8'hFF.
- EMIT ordering: row-major, col 0..ROW_WIDTH-1, then row+1.
- EMIT→DONE on the accepted pixel with o_pix_last=1.
- DONE, one cycle: o_done=1, then return to IDLE.
- i_start is ignored outside IDLE. Operand changes after capture have no effect.
- o_err holds its value until the next LOAD.

## Timing
- Reset values: o_busy=0, o_err=0, o_done=0, o_pix_valid=0, o_pix_data=8'hFF, o_pix_row=0, o_pix_col=0, o_pix_last=0. State is IDLE.
- All outputs are registered.
- Start at edge N gives LOAD in cycle N+1 and o_pix_valid=1 from edge N+2.
- A transfer occurs on an edge where o_pix_valid and i_pix_ready are both high.
- While o_pix_valid=1 and i_pix_ready=0, data/row/col/last are held stable. Valid never drops before a transfer.
- With ready tied high: one pixel per cycle, ROW_WIDTH×BAR_HEIGHT cycles in EMIT. o_done asserts the cycle after the last transfer.
- o_pix_valid is 0 in IDLE, LOAD and DONE.
- Counter wrap: col wraps ROW_WIDTH-1→0 with row+1. No wrap past the last row; the FSM exits instead.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The next i_start begins at row 0, col 0.

## Configuration
- BARCODE_RASTER_WORD_OUT_EN defined: adds two ports.
  - o_barcode  out  57: the assembled frame word.
  - o_barcode_valid  out  1: one-cycle pulse on LOAD→EMIT.
  - o_barcode holds until the next valid LOAD.
- Not defined: the ports do not exist; the word lives only in internal state. Pixel behaviour is identical either way.

## Test plan
- Legal request, defaults: k=1, s=2, d=3, ready=1.
  - 640 pixels are emitted.
  - Row 0, cols 0..10 = 00,00,FF,00,FF,FF,00,00,00,FF,FF; cols 57..63 = FF.
  - o_pix_last at row 9 col 63; o_done exactly one cycle later; o_err=0.
- Illegal request: k=4, s=1, d=1.
  - o_pix_valid stays 0 throughout.
  - o_err=1 and o_done pulses 2 cycles after start.
  - A following legal start clears o_err in LOAD.
- Backpressure: ready random 50%.
  - Every stalled cycle holds data, row and col.
  - The accepted sequence equals the ready=1 capture; exactly 640 transfers.
- Start while busy: pulse i_start mid-EMIT with k=3. Frame content unchanged; no second frame follows.
- Reset mid-frame: assert i_rst_n=0 at transfer 100.
  - o_pix_valid=0 immediately.
  - New start with k=s=d=1 emits a full frame from row 0, col 0.
- Macro defined, k=1, s=2, d=3:
  - o_barcode = 11010011100_11001101100_11001100110_10010011000_1100011101011.
  - o_barcode_valid pulses once.

Source files
------------

// File: rtl/barcode_raster_gen.sv
// ============================================================================
// barcode_raster_gen : streams a 57-module Code 128-C style config barcode
//                      (start, kernel, stride, dilation, stop) as raster rows.
// Optional macro BARCODE_RASTER_WORD_OUT_EN exposes the assembled frame word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module barcode_raster_gen #(
  parameter int unsigned ROW_WIDTH  = 64,
  parameter int unsigned COL_OFFSET = 0,
  parameter int unsigned BAR_HEIGHT = 10
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [7:0]                    i_kernel_size,
  input  logic [7:0]                    i_stride_size,
  input  logic [7:0]                    i_dilation_size,
  output logic                          o_busy,
  output logic                          o_err,
  output logic                          o_done,
  output logic                          o_pix_valid,
  input  logic                          i_pix_ready,
  output logic [7:0]                    o_pix_data,
  output logic [$clog2(BAR_HEIGHT)-1:0] o_pix_row,
  output logic [$clog2(ROW_WIDTH)-1:0]  o_pix_col,
  output logic                          o_pix_last
`ifdef BARCODE_RASTER_WORD_OUT_EN
  ,
  output logic [56:0]                   o_barcode,
  output logic                          o_barcode_valid
`endif
);

  localparam int unsigned CW = $clog2(ROW_WIDTH);
  localparam int unsigned RW = $clog2(BAR_HEIGHT);
  localparam logic [10:0] C_START = 11'b11010011100;
  localparam logic [12:0] C_STOP  = 13'b1100011101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      kern_q, kern_d, strd_q, strd_d, dil_q, dil_d;
  logic [56:0]     word_q, word_d;
  logic            busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic            pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
  logic [7:0]      pix_data_q, pix_data_d;
  logic [RW-1:0]   pix_row_q, pix_row_d, row_nxt;
  logic [CW-1:0]   pix_col_q, pix_col_d, col_nxt;
  logic [56:0]     word_new;
  logic            xfer;
`ifdef BARCODE_RASTER_WORD_OUT_EN
  logic            barcode_valid_q, barcode_valid_d;
`endif

  function automatic logic [10:0] sym_bits(input logic [7:0] v);
    case (v)
      8'd1:    return 11'b11001101100;
      8'd2:    return 11'b11001100110;
      8'd3:    return 11'b10010011000;
      default: return 11'b00000000000;
    endcase
  endfunction

  function automatic logic legal(input logic [7:0] v);
    return (v >= 8'd1) && (v <= 8'd3);
  endfunction

  // Columns left of the offset wrap to a huge unsigned value and fall into padding.
  function automatic logic [7:0] pix_of(input logic [56:0] w, input logic [CW-1:0] c);
    int unsigned rel;
    rel = 32'(c) - COL_OFFSET;
    if (rel <= 32'd56) return w[6'(32'd56 - rel)] ? 8'h00 : 8'hFF;
    return 8'hFF;
  endfunction

  always_comb begin
    state_d     = state_q;
    kern_d      = kern_q;
    strd_d      = strd_q;
    dil_d       = dil_q;
    word_d      = word_q;
    busy_d      = busy_q;
    err_d       = err_q;
    done_d      = 1'b0;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    pix_data_d  = pix_data_q;
    pix_row_d   = pix_row_q;
    pix_col_d   = pix_col_q;
`ifdef BARCODE_RASTER_WORD_OUT_EN
    barcode_valid_d = 1'b0;
`endif
    word_new = {C_START, sym_bits(kern_q), sym_bits(strd_q), sym_bits(dil_q), C_STOP};
    xfer     = pix_valid_q & i_pix_ready;
    if (pix_col_q == CW'(ROW_WIDTH - 1)) begin
      col_nxt = '0;
      row_nxt = pix_row_q + 1'b1;
    end else begin
      col_nxt = pix_col_q + 1'b1;
      row_nxt = pix_row_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          kern_d  = i_kernel_size;
          strd_d  = i_stride_size;
          dil_d   = i_dilation_size;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (legal(kern_q) && legal(strd_q) && legal(dil_q)) begin
          err_d       = 1'b0;
          word_d      = word_new;
          pix_row_d   = '0;
          pix_col_d   = '0;
          pix_valid_d = 1'b1;
          pix_last_d  = 1'b0;
          pix_data_d  = pix_of(word_new, '0);
          state_d     = ST_EMIT;
`ifdef BARCODE_RASTER_WORD_OUT_EN
          barcode_valid_d = 1'b1;
`endif
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_EMIT: begin
        if (xfer) begin
          if (pix_last_q) begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            pix_data_d  = 8'hFF;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            pix_row_d  = row_nxt;
            pix_col_d  = col_nxt;
            pix_data_d = pix_of(word_q, col_nxt);
            pix_last_d = (row_nxt == RW'(BAR_HEIGHT - 1)) && (col_nxt == CW'(ROW_WIDTH - 1));
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      kern_q      <= '0;
      strd_q      <= '0;
      dil_q       <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= 8'hFF;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
`ifdef BARCODE_RASTER_WORD_OUT_EN
      barcode_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kern_q      <= kern_d;
      strd_q      <= strd_d;
      dil_q       <= dil_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      pix_data_q  <= pix_data_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
`ifdef BARCODE_RASTER_WORD_OUT_EN
      barcode_valid_q <= barcode_valid_d;
`endif
    end
  end

  assign o_busy      = busy_q;
  assign o_err       = err_q;
  assign o_done      = done_q;
  assign o_pix_valid = pix_valid_q;
  assign o_pix_data  = pix_data_q;
  assign o_pix_row   = pix_row_q;
  assign o_pix_col   = pix_col_q;
  assign o_pix_last  = pix_last_q;
`ifdef BARCODE_RASTER_WORD_OUT_EN
  assign o_barcode       = word_q;
  assign o_barcode_valid = barcode_valid_q;
`endif

endmodule

`default_nettype wire
